// File: rtl/da_pkg.sv
// Shared constants, types and the sine quarter-wave table generator for the
// dual-channel DAC waveform generator.
package da_pkg;

  localparam int unsigned BUS_W     = 16;
  localparam int unsigned DAC_W     = 14;
  localparam int unsigned PHASE_W   = 10;
  localparam int unsigned AMP_W     = 10;
  localparam int unsigned ROM_AW    = 8;
  localparam int unsigned ROM_DW    = 13;
  localparam int unsigned ROM_DEPTH = 256;

  localparam logic [BUS_W-1:0] ADDR_AMPA_DEF   = 16'h000C;
  localparam logic [BUS_W-1:0] ADDR_AMPB_DEF   = 16'h000D;
  localparam logic [BUS_W-1:0] ADDR_WAVE_DEF   = 16'h000E;
  localparam logic [BUS_W-1:0] ADDR_COMMIT_DEF = 16'h000F;

  localparam int MIDSCALE  = 8192;
  localparam int FULLSCALE = 8191;

  typedef enum logic [1:0] {
    SINE   = 2'b00,
    TRI    = 2'b01,
    SQUARE = 2'b10,
    ZERO   = 2'b11
  } wave_e;

  // Everything that determines one output sample; a change here means an update pulse.
  typedef struct packed {
    logic [PHASE_W-1:0] ph;
    logic [AMP_W-1:0]   amp;
    wave_e              wave;
  } ch_state_t;

  localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

  // rom[k] = round(8191*sin(2*pi*(k+0.5)/1024)), Taylor series in Q60 at elaboration.
  function automatic logic [ROM_DEPTH*ROM_DW-1:0] sine_rom_init();
    logic [ROM_DEPTH*ROM_DW-1:0] tbl;
    logic signed [127:0]         x;
    logic signed [127:0]         x2;
    logic signed [127:0]         term;
    logic signed [127:0]         acc;
    tbl = '0;
    for (int k = 0; k < int'(ROM_DEPTH); k++) begin
      x    = (PI_Q60 * 128'(2 * k + 1)) >>> 10;
      x2   = (x * x) >>> 60;
      term = x;
      acc  = x;
      for (int n = 1; n <= 10; n++) begin
        term = -(((term * x2) >>> 60) / 128'(2 * n * (2 * n + 1)));
        acc  = acc + term;
      end
      tbl[k*ROM_DW +: ROM_DW] = ROM_DW'((acc * 128'sd8191 + (128'sd1 <<< 59)) >>> 60);
    end
    return tbl;
  endfunction

endpackage

// File: rtl/da_sine_rom.sv
// Quarter-wave sine table, 256 x 13 bit, registered read (one cycle latency).
module da_sine_rom
  import da_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROM_AW-1:0] addr,
  output logic [ROM_DW-1:0] data
);

  localparam logic [ROM_DEPTH*ROM_DW-1:0] ROM_BITS = sine_rom_init();

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= '0;
    else        data <= ROM_BITS[32'(addr)*ROM_DW +: ROM_DW];
  end

endmodule

// File: rtl/da_wave_gen.sv
// Two independent DAC waveform channels: phase capture, waveform synthesis,
// double-buffered amplitude scaling and offset-binary output with update pulses.
module da_wave_gen
  import da_pkg::*;
#(
  parameter logic [BUS_W-1:0] ADDR_AMPA   = ADDR_AMPA_DEF,
  parameter logic [BUS_W-1:0] ADDR_AMPB   = ADDR_AMPB_DEF,
  parameter logic [BUS_W-1:0] ADDR_WAVE   = ADDR_WAVE_DEF,
  parameter logic [BUS_W-1:0] ADDR_COMMIT = ADDR_COMMIT_DEF
) (
  input  logic               CLK_BASE,
  input  logic               RST_N,
  input  logic [PHASE_W-1:0] PHASE_A,
  input  logic [PHASE_W-1:0] PHASE_B,
  input  logic               CS,
  input  logic               WR_EN,
  input  logic [BUS_W-1:0]   ADDR,
  input  logic [BUS_W-1:0]   DATA_IN,
  output logic [DAC_W-1:0]   DA_A_DATA,
  output logic [DAC_W-1:0]   DA_B_DATA,
  output logic               DA_A_UPD,
  output logic               DA_B_UPD
);

  localparam int unsigned NCH = 2;
  localparam logic signed [DAC_W-1:0] FS_S = DAC_W'(FULLSCALE);

  logic               wr_c;
  logic               unused_data;
  logic [PHASE_W-1:0] phase_in [NCH];
  logic [DAC_W-1:0]   da_data  [NCH];
  logic               da_upd   [NCH];

  assign wr_c        = !CS && WR_EN;
  assign unused_data = ^DATA_IN[BUS_W-1:AMP_W];
  assign phase_in[0] = PHASE_A;
  assign phase_in[1] = PHASE_B;
  assign DA_A_DATA   = da_data[0];
  assign DA_B_DATA   = da_data[1];
  assign DA_A_UPD    = da_upd[0];
  assign DA_B_UPD    = da_upd[1];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [BUS_W-1:0] ADDR_AMP = (c == 0) ? ADDR_AMPA : ADDR_AMPB;

    logic [PHASE_W-1:0]        p1, p2;
    logic [AMP_W-1:0]          shadow;
    ch_state_t                 cur, prev, s1;
    logic                      s1_chg, s2_chg;
    logic                      load_c, wrap_c, commit_c;
    logic [ROM_AW-1:0]         rom_addr;
    logic [ROM_DW-1:0]         rom_q;
    logic signed [DAC_W-1:0]   sine_c, sample_c, s2_sample;
    logic signed [15:0]        ph_s, tri_c;
    logic [AMP_W-1:0]          s2_amp;
    logic signed [DAC_W+AMP_W:0] prod_c;
    logic [DAC_W-1:0]          data_q;
    logic                      upd_q;

    assign load_c   = (p1 == p2);
    assign wrap_c   = load_c && (p2 < cur.ph);
    assign commit_c = wr_c && (ADDR == ADDR_COMMIT) && DATA_IN[c];

    // Two-stage capture of the asynchronous phase word, register file and held state.
    always_ff @(posedge CLK_BASE or negedge RST_N) begin
      if (!RST_N) begin
        p1     <= '0;
        p2     <= '0;
        shadow <= '0;
        cur    <= '0;
        prev   <= '0;
      end else begin
        p1   <= phase_in[c];
        p2   <= p1;
        prev <= cur;
        if (load_c)               cur.ph   <= p2;
        if (wrap_c || commit_c)   cur.amp  <= shadow;
        if (wr_c && (ADDR == ADDR_WAVE)) cur.wave <= wave_e'(DATA_IN[2*c +: 2]);
        if (wr_c && (ADDR == ADDR_AMP))  shadow   <= DATA_IN[AMP_W-1:0];
      end
    end

    // Odd quadrants read the table mirrored.
    assign rom_addr = cur.ph[ROM_AW] ? ~cur.ph[ROM_AW-1:0] : cur.ph[ROM_AW-1:0];

    da_sine_rom u_rom (
      .clk   (CLK_BASE),
      .rst_n (RST_N),
      .addr  (rom_addr),
      .data  (rom_q)
    );

    assign sine_c = signed'({1'b0, rom_q});

    always_comb begin
      ph_s     = signed'(16'(s1.ph));
      tri_c    = '0;
      sample_c = '0;
      if (s1.ph < PHASE_W'(256))      tri_c = ph_s <<< 5;
      else if (s1.ph < PHASE_W'(768)) tri_c = (16'sd512 - ph_s) <<< 5;
      else                            tri_c = (ph_s - 16'sd1024) <<< 5;
      case (s1.wave)
        SINE:    sample_c = s1.ph[PHASE_W-1] ? -sine_c : sine_c;
        TRI: begin
          if (tri_c > 16'(FULLSCALE))       sample_c = FS_S;
          else if (tri_c < -16'(FULLSCALE)) sample_c = -FS_S;
          else                              sample_c = DAC_W'(tri_c);
        end
        SQUARE:  sample_c = s1.ph[PHASE_W-1] ? -FS_S : FS_S;
        default: sample_c = '0;
      endcase
    end

    assign prod_c = 25'(s2_sample) * 25'(signed'({1'b0, s2_amp}));

    // Amplitude and wave code travel with their phase so every output is self-consistent.
    always_ff @(posedge CLK_BASE or negedge RST_N) begin
      if (!RST_N) begin
        s1        <= '0;
        s1_chg    <= 1'b0;
        s2_sample <= '0;
        s2_amp    <= '0;
        s2_chg    <= 1'b0;
        data_q    <= DAC_W'(MIDSCALE);
        upd_q     <= 1'b0;
      end else begin
        s1        <= cur;
        s1_chg    <= (cur != prev);
        s2_sample <= sample_c;
        s2_amp    <= s1.amp;
        s2_chg    <= s1_chg;
        data_q    <= DAC_W'(prod_c >>> AMP_W) + DAC_W'(MIDSCALE);
        upd_q     <= s2_chg;
      end
    end

    assign da_data[c] = data_q;
    assign da_upd[c]  = upd_q;
  end

endmodule

// File: tb/tb_da_wave_gen.sv
// Self-checking bench for da_wave_gen: directed vector table, corner sequences
// and randomized traffic against a behavioural reference model.
module tb_da_wave_gen;

  localparam logic [15:0] A_AMPA = 16'h000C;
  localparam logic [15:0] A_AMPB = 16'h000D;
  localparam logic [15:0] A_WAVE = 16'h000E;
  localparam logic [15:0] A_COMM = 16'h000F;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b1;
  logic        wr_en = 1'b0;
  logic [9:0]  phase_a = '0;
  logic [9:0]  phase_b = '0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [13:0] da_a, da_b;
  logic        upd_a, upd_b;

  int n_vec = 0;
  int n_bad = 0;
  int upd_cnt [2];

  // Model: sampled phases, held phase, shadow/active amp, wave, and history of held state.
  int m_p1 [2], m_p2 [2], m_ph [2], m_sh [2], m_amp [2], m_wave [2];
  int h_ph [2][5], h_amp [2][5], h_wave [2][5];

  typedef struct {
    int chan;
    int wave;
    int amp;
    int phase;
    int exp_data;
  } vec_t;

  vec_t vecs [11];

  da_wave_gen dut (
    .CLK_BASE  (clk),
    .RST_N     (rst_n),
    .PHASE_A   (phase_a),
    .PHASE_B   (phase_b),
    .CS        (cs),
    .WR_EN     (wr_en),
    .ADDR      (addr),
    .DATA_IN   (data_in),
    .DA_A_DATA (da_a),
    .DA_B_DATA (da_b),
    .DA_A_UPD  (upd_a),
    .DA_B_UPD  (upd_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int ref_sample(input int wave, input int ph);
    int k, r, s;
    s = 0;
    case (wave)
      0: begin
        k = (((ph / 256) % 2) == 0) ? (ph % 256) : (255 - ph % 256);
        r = int'(8191.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 1024.0));
        s = (ph >= 512) ? -r : r;
      end
      1: begin
        if (ph < 256)      s = ph * 32;
        else if (ph < 768) s = (512 - ph) * 32;
        else               s = (ph - 1024) * 32;
        if (s > 8191)  s = 8191;
        if (s < -8191) s = -8191;
      end
      2: s = (ph < 512) ? 8191 : -8191;
      default: s = 0;
    endcase
    return s;
  endfunction

  function automatic int ref_out(input int wave, input int ph, input int amp);
    return 8192 + int'($floor(real'(ref_sample(wave, ph) * amp) / 1024.0));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_p1[c] = 0; m_p2[c] = 0; m_ph[c] = 0; m_sh[c] = 0; m_amp[c] = 0; m_wave[c] = 0;
      for (int j = 0; j < 5; j++) begin
        h_ph[c][j] = 0; h_amp[c][j] = 0; h_wave[c][j] = 0;
      end
    end
  endtask

  task automatic model_edge();
    bit wr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wr = !cs && wr_en;
    for (int c = 0; c < 2; c++) begin
      int nph, namp, nsh, nwave;
      nph = m_ph[c]; namp = m_amp[c]; nsh = m_sh[c]; nwave = m_wave[c];
      if (m_p1[c] == m_p2[c]) begin
        if (m_p2[c] < m_ph[c]) namp = m_sh[c];
        nph = m_p2[c];
      end
      if (wr && addr == A_COMM && data_in[c]) namp = m_sh[c];
      if (wr && addr == ((c == 0) ? A_AMPA : A_AMPB)) nsh = int'(data_in) % 1024;
      if (wr && addr == A_WAVE) nwave = (int'(data_in) >> (2 * c)) % 4;
      m_p2[c] = m_p1[c];
      m_p1[c] = (c == 0) ? int'(phase_a) : int'(phase_b);
      m_ph[c] = nph; m_amp[c] = namp; m_sh[c] = nsh; m_wave[c] = nwave;
      for (int j = 4; j > 0; j--) begin
        h_ph[c][j] = h_ph[c][j-1]; h_amp[c][j] = h_amp[c][j-1]; h_wave[c][j] = h_wave[c][j-1];
      end
      h_ph[c][0] = nph; h_amp[c][0] = namp; h_wave[c][0] = nwave;
    end
  endtask

  // One clock: model advances with the inputs seen at the edge, then outputs are compared.
  task automatic step();
    int ed, eu;
    @(posedge clk);
    #1;
    model_edge();
    for (int c = 0; c < 2; c++) begin
      ed = ref_out(h_wave[c][3], h_ph[c][3], h_amp[c][3]);
      eu = (h_ph[c][3] != h_ph[c][4] || h_amp[c][3] != h_amp[c][4] ||
            h_wave[c][3] != h_wave[c][4]) ? 1 : 0;
      check((c == 0) ? "model_da_a" : "model_da_b", (c == 0) ? int'(da_a) : int'(da_b), ed);
      check((c == 0) ? "model_upd_a" : "model_upd_b", (c == 0) ? int'(upd_a) : int'(upd_b), eu);
    end
    upd_cnt[0] += int'(upd_a);
    upd_cnt[1] += int'(upd_b);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    cs = 1'b0; wr_en = 1'b1; addr = a; data_in = d;
    step();
    cs = 1'b1; wr_en = 1'b0;
  endtask

  task automatic set_phase(input int c, input int p);
    if (c == 0) phase_a = 10'(p);
    else        phase_b = 10'(p);
  endtask

  initial begin
    model_reset();
    upd_cnt[0] = 0;
    upd_cnt[1] = 0;
    vecs[0]  = '{0, 0, 1023, 256, 'h3FF7};
    vecs[1]  = '{1, 2, 512,  600, 'h1000};
    vecs[2]  = '{0, 1, 1023, 128, 'h2FFC};
    vecs[3]  = '{0, 1, 1023, 256, 'h3FF7};
    vecs[4]  = '{1, 1, 1023, 768, 'h0008};
    vecs[5]  = '{0, 0, 1023, 768, 'h0008};
    vecs[6]  = '{1, 0, 1023, 0,   'h2018};
    vecs[7]  = '{0, 0, 1023, 512, 'h1FE7};
    vecs[8]  = '{1, 2, 512,  100, 'h2FFF};
    vecs[9]  = '{0, 3, 1023, 300, 'h2000};
    vecs[10] = '{0, 2, 1023, 0,   'h3FF7};

    // Reset state
    hold(2);
    check("reset_da_a", int'(da_a), 'h2000);
    check("reset_da_b", int'(da_b), 'h2000);
    check("reset_upd", int'(upd_a) + int'(upd_b), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold(4);

    // Directed vector table
    foreach (vecs[i]) begin
      bus_write(A_WAVE, 16'((vecs[i].wave << 2) | vecs[i].wave));
      bus_write(vecs[i].chan == 0 ? A_AMPA : A_AMPB, 16'(vecs[i].amp));
      set_phase(vecs[i].chan, vecs[i].phase);
      hold(3);
      upd_cnt[vecs[i].chan] = 0;
      bus_write(A_COMM, 16'(1 << vecs[i].chan));
      hold(6);
      check($sformatf("vec%0d_data", i), vecs[i].chan == 0 ? int'(da_a) : int'(da_b), vecs[i].exp_data);
      check($sformatf("vec%0d_upd_seen", i), (upd_cnt[vecs[i].chan] > 0) ? 1 : 0, 1);
    end

    // Amplitude double buffer across a ramp and wrap, then forced commit
    bus_write(A_WAVE, 16'h0000);
    bus_write(A_AMPA, 16'd1023);
    set_phase(0, 0); hold(3);
    bus_write(A_COMM, 16'h0001); hold(6);
    bus_write(A_AMPA, 16'd100);
    for (int k = 0; k < 16; k++) begin
      set_phase(0, k * 64);
      hold(k == 4 ? 7 : 4);
      if (k == 4) check("dbuf_pre_wrap", int'(da_a), 'h3FF7);
    end
    set_phase(0, 1023); hold(4);
    set_phase(0, 0);    hold(4);
    set_phase(0, 256);  hold(7);
    check("dbuf_post_wrap", int'(da_a), 'h231F);
    bus_write(A_AMPA, 16'd1023); hold(2);
    check("dbuf_shadow_only", int'(da_a), 'h231F);
    bus_write(A_COMM, 16'h0001); hold(3);
    check("dbuf_commit", int'(da_a), 'h3FF7);

    // Phase changing every cycle never updates the held phase
    upd_cnt[0] = 0;
    for (int i = 0; i < 20; i++) begin
      set_phase(0, (i % 2 == 0) ? 5 : 6);
      step();
    end
    check("unstable_data", int'(da_a), 'h3FF7);
    check("unstable_no_upd", upd_cnt[0], 0);

    // Wrap coinciding with a shadow write keeps the pre-write shadow
    bus_write(A_AMPA, 16'd1023);
    set_phase(0, 800); hold(3);
    bus_write(A_COMM, 16'h0001); hold(4);
    bus_write(A_AMPA, 16'd300);
    set_phase(0, 0);
    hold(2);
    bus_write(A_AMPA, 16'd700);
    set_phase(0, 256); hold(7);
    check("coincide_old_shadow", int'(da_a), 'h295F);
    set_phase(0, 0);   hold(4);
    set_phase(0, 256); hold(7);
    check("coincide_next_wrap", int'(da_a), 'h35DF);

    // Randomized traffic
    begin
      int hc [2];
      int sel;
      hc[0] = 0; hc[1] = 0;
      for (int n = 0; n < 3000; n++) begin
        for (int c = 0; c < 2; c++) begin
          if (hc[c] == 0) begin
            set_phase(c, int'($urandom_range(0, 1023)));
            hc[c] = int'($urandom_range(0, 6));
          end else hc[c]--;
        end
        sel = int'($urandom_range(0, 99));
        cs = 1'b1; wr_en = 1'b0;
        if (sel < 15) begin
          cs = 1'b0; wr_en = 1'b1; data_in = 16'($urandom);
          case ($urandom_range(0, 4))
            0: addr = A_AMPA;
            1: addr = A_AMPB;
            2: addr = A_WAVE;
            3: addr = A_COMM;
            default: addr = 16'($urandom);
          endcase
        end else if (sel < 25) begin
          cs = 1'($urandom); wr_en = ~cs; addr = A_AMPA; data_in = 16'($urandom);
        end
        step();
      end
      cs = 1'b1; wr_en = 1'b0;
    end

    // Reset mid-stream forces idle outputs; they hold until an amplitude commit
    bus_write(A_AMPA, 16'd1023); bus_write(A_AMPB, 16'd1023);
    bus_write(A_WAVE, 16'h0008);
    set_phase(0, 256); set_phase(1, 100); hold(3);
    bus_write(A_COMM, 16'h0003); hold(2);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_da_a", int'(da_a), 'h2000);
    check("rst_mid_da_b", int'(da_b), 'h2000);
    check("rst_mid_upd", int'(upd_a) + int'(upd_b), 0);
    hold(3);
    rst_n = 1'b1;
    set_phase(0, 300); set_phase(1, 700);
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_hold_a", int'(da_a), 'h2000);
      check("rst_hold_b", int'(da_b), 'h2000);
    end
    bus_write(A_AMPA, 16'd1023); hold(3);
    check("rst_hold_shadow_a", int'(da_a), 'h2000);
    bus_write(A_COMM, 16'h0001); hold(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
